clk_div_gen: RTL and testbench
==============================

CLK_DIV_GEN -- requirements
Module: clk_div_gen

Interface
- REQ-001: The block SHALL have one clock and a synchronous, active-high reset named as below.
- REQ-002: Parameter WIDTH, default 8: width of the period and high-time fields.
- REQ-003: Parameter DEF_PERIOD, default 2: period, in clk cycles, after reset.
- REQ-004: Parameter DEF_HIGH, default 1: high time, in clk cycles, after reset.
- REQ-005: clk  in  1  system clock (25 MHz nominal); all logic on rising edge.
- REQ-006: rst  in  1  synchronous active-high reset.
- REQ-007: en  in  1  run request; level-sensitive.
- REQ-008: load  in  1  one-cycle strobe; captures period_in/high_in.
- REQ-009: period_in  in  WIDTH  requested period, in clk cycles.
- REQ-010: high_in  in  WIDTH  requested high time, in clk cycles.
- REQ-011: clk_out  out  1  divided clock; registered, glitch-free.
- REQ-012: tick  out  1  one-cycle pulse at each clk_out rising edge.
- REQ-013: busy  out  1  high while the FSM is not IDLE.
- REQ-014: cfg_err  out  1  one-cycle pulse when a load is rejected.
- REQ-015: periods  out  16  count of completed periods (see Configuration).

Function
- REQ-016: FSM states SHALL be IDLE, HIGH and LOW, with a WIDTH-bit counter cnt; all outputs SHALL be registered.
- REQ-017: Active settings (per_r, high_r) SHALL apply when cnt wraps and at each start from IDLE; pending settings (per_p, high_p) SHALL be written by load.
- REQ-018: A load SHALL be valid only when period_in>=2 and 1<=high_in<=period_in-1; otherwise pending settings stay unchanged and cfg_err pulses the cycle after load.
- REQ-019: IDLE->HIGH SHALL occur at the edge where en=1; on that edge cnt=0, active<=pending, clk_out=1, tick=1, busy=1.
- REQ-020: In HIGH/LOW, cnt SHALL increment each cycle.
- REQ-021: clk_out SHALL be 1 while cnt<high_r; HIGH->LOW SHALL occur when cnt reaches high_r.
- REQ-022: At cnt==per_r-1 (period end), cnt SHALL wrap to 0.
- REQ-023: At period end, if en=1, the FSM SHALL enter HIGH with active<=pending and tick=1; if en=0, it SHALL enter IDLE with clk_out=0 and busy=0.
- REQ-024: Deasserting en mid-period SHALL never shorten the current high or low phase; no runt pulses are permitted.
- REQ-025: A valid load with en=1 in IDLE on the same edge SHALL be used for the first period.
- REQ-026: A load during a run SHALL take effect only at the next period boundary.
- REQ-027: A second load before that boundary SHALL overwrite the pending settings (last valid load wins).
- REQ-028: tick SHALL be 0 in all cycles other than those in REQ-019 and REQ-023; cfg_err SHALL be 0 except as in REQ-018.

Reset
- REQ-029: On rst=1 at an edge, the FSM SHALL go to IDLE with cnt=0, clk_out=0, tick=0, busy=0, cfg_err=0 and periods=0.
- REQ-030: On rst=1 at an edge, pending and active settings SHALL be set to DEF_PERIOD/DEF_HIGH; this applies mid-period and overrides load and en.
- REQ-031: Operation SHALL resume no earlier than the first edge with rst=0 and en=1.

Configuration
- REQ-032: Macro CLK_DIV_GEN_PERIOD_CNT_EN SHALL control the period counter.
- REQ-033: When CLK_DIV_GEN_PERIOD_CNT_EN is defined, periods SHALL increment by 1 at every completed period end (REQ-022), saturating at 16'hFFFF.
- REQ-034: When CLK_DIV_GEN_PERIOD_CNT_EN is undefined, periods SHALL be constant 0 and no counter flops SHALL be inferred.

Verification
- REQ-035: Reset release, then en=1 with defaults -> clk_out toggles every cycle (1,0,1,0) and tick every 2 cycles.
- REQ-036: load period_in=4, high_in=2, then en=1 -> clk_out 1100 repeating, tick every 4th cycle, busy=1.
- REQ-037: load period_in=1, high_in=1, then load period_in=5, high_in=5 -> cfg_err pulses twice and the running waveform is unchanged.
- REQ-038: Running 4/2, load 5/1 at cnt=1 -> the current period completes as 1100, then 10000 repeats.
- REQ-039: Running 4/2, en=0 at cnt=0 -> the period completes (1100) then IDLE; rst=1 at cnt=1 in another run -> clk_out=0 and busy=0 after that edge.
- REQ-040: With CLK_DIV_GEN_PERIOD_CNT_EN defined, 10 periods -> periods=10; with it undefined -> periods=0.

Source files
------------

// File: rtl/clk_div_gen_if.sv
// Control/status bundle for clk_div_gen: run/load requests in, divided clock and status out.
interface clk_div_gen_if #(
   parameter int unsigned WIDTH = 8
);
   logic             en;
   logic             load;
   logic [WIDTH-1:0] period_in;
   logic [WIDTH-1:0] high_in;
   logic             clk_out;
   logic             tick;
   logic             busy;
   logic             cfg_err;
   logic [15:0]      periods;

   modport master (
      output en, load, period_in, high_in,
      input  clk_out, tick, busy, cfg_err, periods
   );

   modport slave (
      input  en, load, period_in, high_in,
      output clk_out, tick, busy, cfg_err, periods
   );
endinterface

// File: rtl/clk_div_gen.sv
// Programmable glitch-free clock divider with period/high-time reload at period boundaries.
// Optional completed-period counter enabled by defining CLK_DIV_GEN_PERIOD_CNT_EN.
module clk_div_gen #(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned DEF_PERIOD = 2,
   parameter int unsigned DEF_HIGH   = 1
) (
   input  logic          clk,
   input  logic          rst,
   clk_div_gen_if.slave  bus
);

   localparam logic [WIDTH-1:0] DEF_PER_W  = WIDTH'(DEF_PERIOD);
   localparam logic [WIDTH-1:0] DEF_HIGH_W = WIDTH'(DEF_HIGH);
   localparam logic [WIDTH-1:0] ONE_W      = WIDTH'(1);
   localparam logic [WIDTH-1:0] TWO_W      = WIDTH'(2);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] per_r_q, per_r_d;
   logic [WIDTH-1:0] high_r_q, high_r_d;
   logic [WIDTH-1:0] per_p_q, per_p_d;
   logic [WIDTH-1:0] high_p_q, high_p_d;
   logic             clk_out_q, clk_out_d;
   logic             tick_q, tick_d;
   logic             busy_q, busy_d;
   logic             cfg_err_q, cfg_err_d;

   logic             load_ok;
   logic [WIDTH-1:0] per_eff;
   logic [WIDTH-1:0] high_eff;
   logic [WIDTH-1:0] cnt_inc;
   logic             at_end;

   // Load qualification; a same-edge valid load is visible to a period start.
   always_comb begin
      load_ok  = bus.load
               && (bus.period_in >= TWO_W)
               && (bus.high_in != '0)
               && (bus.high_in < bus.period_in);
      per_eff  = load_ok ? bus.period_in : per_p_q;
      high_eff = load_ok ? bus.high_in   : high_p_q;
      cnt_inc  = cnt_q + ONE_W;
      at_end   = (cnt_q == (per_r_q - ONE_W));
   end

   // Next-state and registered-output decode.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      per_r_d   = per_r_q;
      high_r_d  = high_r_q;
      per_p_d   = per_eff;
      high_p_d  = high_eff;
      clk_out_d = clk_out_q;
      tick_d    = 1'b0;
      busy_d    = busy_q;
      cfg_err_d = bus.load && !load_ok;

      unique case (state_q)
         IDLE: begin
            cnt_d     = '0;
            clk_out_d = 1'b0;
            busy_d    = 1'b0;
            if (bus.en) begin
               state_d   = HIGH;
               per_r_d   = per_eff;
               high_r_d  = high_eff;
               clk_out_d = 1'b1;
               tick_d    = 1'b1;
               busy_d    = 1'b1;
            end
         end
         HIGH, LOW: begin
            busy_d = 1'b1;
            if (at_end) begin
               cnt_d = '0;
               if (bus.en) begin
                  state_d   = HIGH;
                  per_r_d   = per_eff;
                  high_r_d  = high_eff;
                  clk_out_d = 1'b1;
                  tick_d    = 1'b1;
               end else begin
                  state_d   = IDLE;
                  clk_out_d = 1'b0;
                  busy_d    = 1'b0;
               end
            end else begin
               // en is only looked at on the boundary, so phases are never cut short.
               cnt_d     = cnt_inc;
               clk_out_d = (cnt_inc < high_r_q);
               if (cnt_inc == high_r_q) begin
                  state_d = LOW;
               end
            end
         end
         default: begin
            state_d   = IDLE;
            cnt_d     = '0;
            clk_out_d = 1'b0;
            busy_d    = 1'b0;
         end
      endcase
   end

   // State and output registers; reset restores the default waveform settings.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         per_r_q   <= DEF_PER_W;
         high_r_q  <= DEF_HIGH_W;
         per_p_q   <= DEF_PER_W;
         high_p_q  <= DEF_HIGH_W;
         clk_out_q <= 1'b0;
         tick_q    <= 1'b0;
         busy_q    <= 1'b0;
         cfg_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         per_r_q   <= per_r_d;
         high_r_q  <= high_r_d;
         per_p_q   <= per_p_d;
         high_p_q  <= high_p_d;
         clk_out_q <= clk_out_d;
         tick_q    <= tick_d;
         busy_q    <= busy_d;
         cfg_err_q <= cfg_err_d;
      end
   end

   assign bus.clk_out = clk_out_q;
   assign bus.tick    = tick_q;
   assign bus.busy    = busy_q;
   assign bus.cfg_err = cfg_err_q;

`ifdef CLK_DIV_GEN_PERIOD_CNT_EN
   logic [15:0] periods_q;
   logic        period_done;

   assign period_done = (state_q != IDLE) && at_end;

   // Saturating count of completed periods.
   always_ff @(posedge clk) begin
      if (rst) begin
         periods_q <= 16'd0;
      end else if (period_done && (periods_q != 16'hFFFF)) begin
         periods_q <= periods_q + 16'd1;
      end
   end

   assign bus.periods = periods_q;
`else
   assign bus.periods = 16'd0;
`endif

endmodule

// File: tb/tb_clk_div_gen.sv
// Directed bench for clk_div_gen: waveform shapes, reload timing, load rejection, reset, period count.
module tb_clk_div_gen;

   localparam int unsigned WIDTH = 8;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;

   clk_div_gen_if #(.WIDTH(WIDTH)) bus ();

   clk_div_gen #(
      .WIDTH      (WIDTH),
      .DEF_PERIOD (2),
      .DEF_HIGH   (1)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #20 clk = ~clk;

   // Advance one edge and settle away from it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Steps n cycles, checking clk_out and tick against patterns given MSB-first.
   task automatic chk_wave(input string tag, input logic [15:0] co, input logic [15:0] tk, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         step();
         chk($sformatf("%s_clk%0d", tag, n - 1 - i), {31'd0, bus.clk_out}, {31'd0, co[i]});
         chk($sformatf("%s_tick%0d", tag, n - 1 - i), {31'd0, bus.tick}, {31'd0, tk[i]});
      end
   endtask

   task automatic do_load(input logic [7:0] p, input logic [7:0] h);
      bus.load      = 1'b1;
      bus.period_in = p;
      bus.high_in   = h;
   endtask

   initial begin
      int exp_periods;
      n_tests       = 0;
      n_fail        = 0;
      rst           = 1'b1;
      bus.en        = 1'b0;
      bus.load      = 1'b0;
      bus.period_in = 8'd0;
      bus.high_in   = 8'd0;
      step();
      step();
      rst = 1'b0;
      step();
      chk("rst_clk", {31'd0, bus.clk_out}, 32'd0);
      chk("rst_tick", {31'd0, bus.tick}, 32'd0);
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_cfg_err", {31'd0, bus.cfg_err}, 32'd0);
      chk("rst_periods", {16'd0, bus.periods}, 32'd0);

      // Defaults: divide by 2.
      bus.en = 1'b1;
      chk_wave("def", 16'b1010, 16'b1010, 4);
      chk("def_busy", {31'd0, bus.busy}, 32'd1);
      bus.en = 1'b0;
      step();
      chk("def_stop_busy", {31'd0, bus.busy}, 32'd0);
      chk("def_stop_clk", {31'd0, bus.clk_out}, 32'd0);

      // Load 4/2 while idle, then run.
      do_load(8'd4, 8'd2);
      step();
      bus.load = 1'b0;
      chk("ld42_cfg_err", {31'd0, bus.cfg_err}, 32'd0);
      chk("ld42_idle_busy", {31'd0, bus.busy}, 32'd0);
      bus.en = 1'b1;
      chk_wave("p42", 16'b11001100, 16'b10001000, 8);
      chk("p42_busy", {31'd0, bus.busy}, 32'd1);

      // Two rejected loads, waveform unchanged.
      do_load(8'd1, 8'd1);
      step();
      chk("bad1_cfg_err", {31'd0, bus.cfg_err}, 32'd1);
      chk("bad1_clk", {31'd0, bus.clk_out}, 32'd1);
      do_load(8'd5, 8'd5);
      step();
      chk("bad2_cfg_err", {31'd0, bus.cfg_err}, 32'd1);
      chk("bad2_clk", {31'd0, bus.clk_out}, 32'd1);
      bus.load = 1'b0;
      step();
      chk("bad_clr_cfg_err", {31'd0, bus.cfg_err}, 32'd0);
      chk("bad_clr_clk", {31'd0, bus.clk_out}, 32'd0);
      step();
      chk_wave("bad_keep", 16'b1100, 16'b1000, 4);

      // Load 5/1 at cnt=1: current period finishes as 1100, then 10000.
      step();
      step();
      chk("mid_cnt1_clk", {31'd0, bus.clk_out}, 32'd1);
      do_load(8'd5, 8'd1);
      step();
      bus.load = 1'b0;
      chk("mid_ld_cfg_err", {31'd0, bus.cfg_err}, 32'd0);
      chk("mid_cnt2_clk", {31'd0, bus.clk_out}, 32'd0);
      step();
      chk("mid_cnt3_clk", {31'd0, bus.clk_out}, 32'd0);
      chk_wave("p51", 16'b1000010000, 16'b1000010000, 10);

      // Back to idle, reload 4/2, drop en at cnt=0.
      bus.en = 1'b0;
      step();
      chk("p51_stop_busy", {31'd0, bus.busy}, 32'd0);
      do_load(8'd4, 8'd2);
      step();
      bus.load = 1'b0;
      bus.en   = 1'b1;
      step();
      chk("en0_start_clk", {31'd0, bus.clk_out}, 32'd1);
      chk("en0_start_tick", {31'd0, bus.tick}, 32'd1);
      bus.en = 1'b0;
      chk_wave("en0", 16'b100, 16'b000, 3);
      chk("en0_cnt3_busy", {31'd0, bus.busy}, 32'd1);
      step();
      chk("en0_end_busy", {31'd0, bus.busy}, 32'd0);
      chk("en0_end_clk", {31'd0, bus.clk_out}, 32'd0);
      chk("en0_end_tick", {31'd0, bus.tick}, 32'd0);

      // Reset at cnt=1 of a 4/2 run; defaults come back.
      bus.en = 1'b1;
      step();
      step();
      chk("mrst_cnt1_clk", {31'd0, bus.clk_out}, 32'd1);
      rst = 1'b1;
      step();
      chk("mrst_clk", {31'd0, bus.clk_out}, 32'd0);
      chk("mrst_busy", {31'd0, bus.busy}, 32'd0);
      chk("mrst_tick", {31'd0, bus.tick}, 32'd0);
      rst = 1'b0;
      chk_wave("mrst_def", 16'b1010, 16'b1010, 4);

      // Ten completed default periods.
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("cnt_rst_periods", {16'd0, bus.periods}, 32'd0);
      for (int i = 0; i < 21; i++) step();
`ifdef CLK_DIV_GEN_PERIOD_CNT_EN
      exp_periods = 10;
`else
      exp_periods = 0;
`endif
      chk("periods10", {16'd0, bus.periods}, 32'(exp_periods));

      // Last valid load before a start wins.
      bus.en = 1'b0;
      step();
      step();
      chk("lw_idle_busy", {31'd0, bus.busy}, 32'd0);
`ifdef CLK_DIV_GEN_PERIOD_CNT_EN
      exp_periods = 11;
`endif
      chk("periods11", {16'd0, bus.periods}, 32'(exp_periods));
      do_load(8'd6, 8'd3);
      step();
      do_load(8'd3, 8'd1);
      step();
      bus.load = 1'b0;
      bus.en   = 1'b1;
      chk_wave("lw31", 16'b100100, 16'b100100, 6);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
